// File: rtl/spi_cmd_decoder.sv
// SPI frame decoder: synchronizes chip-select, latches the three received bytes at
// end of frame, validates the opcode and queues legal commands in a show-ahead FIFO.
module spi_cmd_decoder #(
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          cs,
    input  logic [7:0]                    command_rx,
    input  logic [7:0]                    databyte1_rx,
    input  logic [7:0]                    databyte2_rx,
    output logic                          cmd_valid,
    input  logic                          cmd_ready,
    output logic [7:0]                    cmd_op,
    output logic [7:0]                    cmd_arg1,
    output logic [7:0]                    cmd_arg2,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic [CNT_W-1:0]              err_count,
    output logic [CNT_W-1:0]              ovf_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL_COUNT = FIFO_DEPTH[AW:0];
    localparam logic [AW:0] ONE_COUNT  = 1;

    typedef enum logic [1:0] {IDLE, ARMED, LATCH, DECODE} state_t;

    state_t           r_state;
    logic             r_s1, r_s2, r_s3;
    logic [2:0]       r_primed;
    logic [7:0]       r_holdOp, r_holdArg1, r_holdArg2;
    logic [7:0]       r_memOp   [FIFO_DEPTH];
    logic [7:0]       r_memArg1 [FIFO_DEPTH];
    logic [7:0]       r_memArg2 [FIFO_DEPTH];
    logic [AW-1:0]    r_wrPtr, r_rdPtr;
    logic [AW:0]      r_count;
    logic [CNT_W-1:0] r_errCount, r_ovfCount;

    logic w_rise, w_fall, w_legal, w_pop, w_full, w_decode, w_push, w_drop, w_reject;

    // r_primed marks when r_s3 holds a genuine post-reset sample, so a cs that was
    // already high across reset release never looks like a fresh rise.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1     <= 1'b0;
            r_s2     <= 1'b0;
            r_s3     <= 1'b0;
            r_primed <= '0;
        end else begin
            r_s1     <= cs;
            r_s2     <= r_s1;
            r_s3     <= r_s2;
            r_primed <= {r_primed[1:0], 1'b1};
        end
    end

    assign w_rise = r_s2 & ~r_s3 & r_primed[2];
    assign w_fall = ~r_s2 & r_s3;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_holdOp   <= '0;
            r_holdArg1 <= '0;
            r_holdArg2 <= '0;
        end else begin
            case (r_state)
                IDLE:    if (w_rise) r_state <= ARMED;
                ARMED:   if (w_fall) r_state <= LATCH;
                LATCH: begin
                    r_holdOp   <= command_rx;
                    r_holdArg1 <= databyte1_rx;
                    r_holdArg2 <= databyte2_rx;
                    r_state    <= DECODE;
                end
                DECODE:  r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    always_comb begin
        w_legal = 1'b0;
        case (r_holdOp)
            8'h01:   w_legal = (r_holdArg1 < 8'd4);
            8'h02:   w_legal = (r_holdArg1 < 8'd80) && (r_holdArg2 < 8'd60);
            8'h03:   w_legal = 1'b1;
            8'h04:   w_legal = (r_holdArg1 != 8'd0);
            default: w_legal = 1'b0;
        endcase
    end

    // A full FIFO still accepts the new frame when the head leaves in the same cycle.
    assign w_pop    = cmd_valid & cmd_ready;
    assign w_full   = (r_count == FULL_COUNT);
    assign w_decode = (r_state == DECODE);
    assign w_push   = w_decode & w_legal & (~w_full | w_pop);
    assign w_drop   = w_decode & w_legal & w_full & ~w_pop;
    assign w_reject = w_decode & ~w_legal;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_memOp[r_wrPtr]   <= r_holdOp;
            r_memArg1[r_wrPtr] <= r_holdArg1;
            r_memArg2[r_wrPtr] <= r_holdArg2;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wrPtr <= r_wrPtr + AW'(1);
            if (w_pop)  r_rdPtr <= r_rdPtr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + ONE_COUNT;
                2'b01:   r_count <= r_count - ONE_COUNT;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_errCount <= '0;
            r_ovfCount <= '0;
        end else begin
            if (w_reject && r_errCount != '1) r_errCount <= r_errCount + CNT_W'(1);
            if (w_drop && r_ovfCount != '1)   r_ovfCount <= r_ovfCount + CNT_W'(1);
        end
    end

    assign cmd_valid  = (r_count != '0);
    assign cmd_op     = cmd_valid ? r_memOp[r_rdPtr]   : 8'd0;
    assign cmd_arg1   = cmd_valid ? r_memArg1[r_rdPtr] : 8'd0;
    assign cmd_arg2   = cmd_valid ? r_memArg2[r_rdPtr] : 8'd0;
    assign fifo_count = r_count;
    assign err_count  = r_errCount;
    assign ovf_count  = r_ovfCount;

endmodule
